// File: rtl/seg7_time_display.sv
// Six-digit multiplexed 7-segment scan of HH MM SS with field blinking,
// dashes for out-of-range fields, colon heartbeat and a gated piezo tone.
module seg7_time_display #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 250000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] hour,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [1:0] mode,
   input  logic       trg_alarm,
   output logic [7:0] seg,
   output logic [5:0] dig,
   output logic       buzz
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [SCAN_W-1:0]  presc;
   logic               tick;
   logic               vld_p1;
   logic [2:0]         idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_wrap;
   logic               blink_ph;
   logic [5:0]         hour_p0, min_p0, sec_p0;
   logic [1:0]         mode_p0;
   logic               alarm_p0;
   logic               tone;
   logic               tone_nxt;
   logic               tone_act;
   logic [5:0]         fval;
   logic [5:0]         flim;
   logic [3:0]         digit;
   logic [6:0]         seg7;
   logic               blank;
   logic               dp;
   logic [7:0]         pat_p1;

   // 7-segment font, g..a on bits [6:0]
   function automatic logic [6:0] font(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Tens digit of a 6-bit value; anything >= 60 is never shown as a number
   function automatic logic [3:0] tens_of(input logic [5:0] v);
      if (v >= 6'd60)      return 4'd6;
      else if (v >= 6'd50) return 4'd5;
      else if (v >= 6'd40) return 4'd4;
      else if (v >= 6'd30) return 4'd3;
      else if (v >= 6'd20) return 4'd2;
      else if (v >= 6'd10) return 4'd1;
      else                 return 4'd0;
   endfunction

   function automatic logic [3:0] ones_of(input logic [5:0] v);
      return 4'(v - 6'd10 * {2'b00, tens_of(v)});
   endfunction

   assign tick       = (presc == SCAN_W'(SCAN_DIV - 1));
   assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
   assign tone_act   = trg_alarm && (mode != 2'b11);
   assign tone_nxt   = tone_act ? (tone ^ tick) : 1'b0;

   // Digit-slot prescaler, slot index and the one-cycle load strobe after a tick
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc  <= '0;
         idx    <= 3'd0;
         vld_p1 <= 1'b0;
      end else begin
         presc  <= tick ? '0 : presc + SCAN_W'(1);
         vld_p1 <= tick;
         if (tick)
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
   end

   // Free-running blink phase
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else begin
         blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
         if (blink_wrap)
            blink_ph <= ~blink_ph;
      end
   end

   // Frame-boundary snapshot so a frame never mixes old and new time
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hour_p0  <= 6'd0;
         min_p0   <= 6'd0;
         sec_p0   <= 6'd0;
         mode_p0  <= 2'b00;
         alarm_p0 <= 1'b0;
      end else if (tick && idx == 3'd5) begin
         hour_p0  <= hour;
         min_p0   <= min;
         sec_p0   <= sec;
         mode_p0  <= mode;
         alarm_p0 <= trg_alarm;
      end
   end

   // Segment pattern for the current slot from the snapshot and blink phase
   always_comb begin
      fval   = sec_p0;
      flim   = 6'd59;
      digit  = 4'd0;
      seg7   = 7'h00;
      blank  = 1'b0;
      dp     = 1'b0;
      pat_p1 = 8'h00;
      case (idx[2:1])
         2'd0: begin
            fval = hour_p0;
            flim = 6'd23;
         end
         2'd1: begin
            fval = min_p0;
            flim = 6'd59;
         end
         default: begin
            fval = sec_p0;
            flim = 6'd59;
         end
      endcase
      digit = idx[0] ? ones_of(fval) : tens_of(fval);
      seg7  = (fval > flim) ? 7'h40 : font(digit);
      case (mode_p0)
         2'b01:   blank = blink_ph && (idx <= 3'd1);
         2'b10:   blank = blink_ph && (idx == 3'd2 || idx == 3'd3);
         2'b11:   blank = (idx >= 3'd4);
         default: blank = blink_ph && alarm_p0;
      endcase
      dp     = (idx == 3'd1 || idx == 3'd3) && (mode_p0 != 2'b00 || !blink_ph);
      pat_p1 = blank ? 8'h00 : {dp, seg7};
   end

   // Display drivers: dark for one cycle after each tick, then hold the slot
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seg <= 8'h00;
         dig <= 6'b0;
      end else if (tick) begin
         seg <= 8'h00;
         dig <= 6'b0;
      end else if (vld_p1) begin
         seg <= pat_p1;
         dig <= 6'd1 << idx;
      end
   end

   // Piezo tone: toggles per tick while the alarm is live, silent in the off blink phase
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tone <= 1'b0;
         buzz <= 1'b0;
      end else begin
         tone <= tone_nxt;
         buzz <= tone_nxt & ~blink_ph;
      end
   end

endmodule
